thermo_bubble_stage: RTL and testbench

//  Front-end stage of the 8-bit flash ADC, directly upstream of encoder_256x8.
//  - Takes the raw 255-bit comparator thermometer code.
//  - Synchronises it, removes single bubble errors and converts it to the 256-bit one-hot word the encoder consumes.
//  - Flags non-monotonic samples, over-range samples and counts bubble events for characterisation.

---
 rtl/adc_pkg.sv | 18 +
 rtl/bubble_corrector.sv | 27 ++
 rtl/thermo_bubble_stage.sv | 127 ++++++++++++
 tb/tb_thermo_bubble_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and helpers for the 8-bit flash ADC front end.
package adc_pkg;

  localparam int unsigned ADC_BITS = 8;
  localparam int unsigned N_CODES  = 1 << ADC_BITS;
  localparam int unsigned COMP_W   = N_CODES - 1;

  // Per-sample status carried alongside the code through the pipeline
  typedef struct packed {
    logic bub;
    logic ovr;
  } flags_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bubble_corrector.sv
// Three-input majority filter over a thermometer code, plus raw bubble and
// over-range detection on the unfiltered code.
module bubble_corrector
  import adc_pkg::*;
#(
  parameter int unsigned W = COMP_W
) (
  input  logic [W-1:0] t_i,
  output logic [W-1:0] thermo_c,
  output logic         raw_bub_c,
  output logic         ovr_c
);

  // ext[0] is the implied always-high comparator below bit 0; ext[W+1] the always-low one above the top
  logic [W+1:0] ext;

  always_comb begin
    ext       = {1'b0, t_i, 1'b1};
    thermo_c  = '0;
    for (int i = 0; i < int'(W); i++) begin
      thermo_c[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
    raw_bub_c = |(~t_i[W-2:0] & t_i[W-1:1]);
    ovr_c     = &t_i;
  end

endmodule

// File: rtl/thermo_bubble_stage.sv
// Comparator-bus synchroniser, bubble correction and thermometer-to-one-hot
// conversion feeding the 256x8 encoder, with bubble event statistics.
module thermo_bubble_stage
  import adc_pkg::*;
#(
  parameter int unsigned N_CODES     = adc_pkg::N_CODES,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CODES-2:0] comp_in,
  input  logic               sample_en,
  input  logic               cnt_clr,
  output logic [N_CODES-1:0] onehot_out,
  output logic               valid_out,
  output logic               bubble_err,
  output logic               over_range,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int unsigned CW = N_CODES - 1;

  logic [CW-1:0]      sync_q [SYNC_STAGES];

  logic [CW-1:0]      corr_c;
  logic               raw_bub_c;
  logic               ovr_c;

  logic [CW-1:0]      c_q,       c_d;
  flags_t             flags_c_q, flags_c_d;
  logic               vld_c_q,   vld_c_d;

  logic [N_CODES-1:0] onehot_q,  onehot_d;
  flags_t             flags_o_q, flags_o_d;
  logic               vld_o_q,   vld_o_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [N_CODES:0]   c_ext;
  logic [N_CODES-1:0] pick_c;

  bubble_corrector #(
    .W (CW)
  ) u_corr (
    .t_i       (sync_q[SYNC_STAGES-1]),
    .thermo_c  (corr_c),
    .raw_bub_c (raw_bub_c),
    .ovr_c     (ovr_c)
  );

  // Highest 1->0 transition wins; an empty result falls back to code 0
  always_comb begin
    c_ext  = {1'b0, c_q, 1'b1};
    pick_c = '0;
    for (int k = 0; k < int'(N_CODES); k++) begin
      if (c_ext[k] && !c_ext[k+1]) begin
        pick_c    = '0;
        pick_c[k] = 1'b1;
      end
    end
    if (pick_c == '0) begin
      pick_c = N_CODES'(1);
    end
  end

  always_comb begin
    c_d       = c_q;
    flags_c_d = flags_c_q;
    vld_c_d   = sample_en;
    onehot_d  = onehot_q;
    flags_o_d = flags_o_q;
    vld_o_d   = vld_c_q;
    cnt_d     = cnt_q;

    if (sample_en) begin
      c_d           = corr_c;
      flags_c_d.bub = raw_bub_c;
      flags_c_d.ovr = ovr_c;
    end

    if (vld_c_q) begin
      onehot_d  = pick_c;
      flags_o_d = flags_c_q;
    end

    // Clear beats a simultaneous increment; the count sticks at all-ones
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (vld_o_q && flags_o_q.bub && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      c_q       <= '0;
      flags_c_q <= '0;
      vld_c_q   <= 1'b0;
      onehot_q  <= N_CODES'(1);
      flags_o_q <= '0;
      vld_o_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q[0] <= comp_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      c_q       <= c_d;
      flags_c_q <= flags_c_d;
      vld_c_q   <= vld_c_d;
      onehot_q  <= onehot_d;
      flags_o_q <= flags_o_d;
      vld_o_q   <= vld_o_d;
      cnt_q     <= cnt_d;
    end
  end

  assign onehot_out = onehot_q;
  assign valid_out  = vld_o_q;
  assign bubble_err = flags_o_q.bub;
  assign over_range = flags_o_q.ovr;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_thermo_bubble_stage.sv
// Scoreboard bench for thermo_bubble_stage: expected code/flags queued at
// sample time, compared when valid_out fires; counter tracked by a model.
module tb_thermo_bubble_stage;

  localparam int unsigned NC   = 256;
  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 16;

  typedef struct {
    logic [NC-1:0] oh;
    logic          bub;
    logic          ovr;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NC-2:0]   comp_in;
  logic            sample_en;
  logic            cnt_clr;
  logic [NC-1:0]   onehot_out;
  logic            valid_out;
  logic            bubble_err;
  logic            over_range;
  logic [CW-1:0]   bubble_cnt;

  exp_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  int              n_valid = 0;
  bit              armed = 1'b0;
  logic [NC-1:0]   exp_oh;
  logic            exp_bub;
  logic            exp_ovr;
  logic [CW-1:0]   exp_cnt;

  thermo_bubble_stage #(
    .N_CODES     (NC),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .comp_in    (comp_in),
    .sample_en  (sample_en),
    .cnt_clr    (cnt_clr),
    .onehot_out (onehot_out),
    .valid_out  (valid_out),
    .bubble_err (bubble_err),
    .over_range (over_range),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NC-1:0] got, input logic [NC-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC-2:0] thermo(input int k);
    logic [NC-2:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] code_oh(input int code);
    logic [NC-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  // Hold comp_in long enough to reach the synchroniser output, then sample n times
  task automatic do_sample(input logic [NC-2:0] comp, input int code, input logic bub,
                           input logic ovr, input int n);
    exp_t e;
    comp_in = comp;
    repeat (SYNC) tick();
    for (int i = 0; i < n; i++) begin
      sample_en = 1'b1;
      e.oh  = code_oh(code);
      e.bub = bub;
      e.ovr = ovr;
      sb.push_back(e);
      tick();
    end
    sample_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, NC'(sb.size()), '0);
    sb.delete();
  endtask

  // Output monitor and reference model for hold values and the event counter
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (valid_out === 1'b1) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("unexp_valid", NC'(valid_out), '0);
        end else begin
          e = sb.pop_front();
          exp_oh  = e.oh;
          exp_bub = e.bub;
          exp_ovr = e.ovr;
        end
      end
      check("onehot", onehot_out, exp_oh);
      check("bub", NC'(bubble_err), NC'(exp_bub));
      check("ovr", NC'(over_range), NC'(exp_ovr));
      check("cnt", NC'(bubble_cnt), NC'(exp_cnt));
      check("onehot_pop", NC'($countones(onehot_out)), NC'(1));
    end
    if (rst) begin
      armed   = 1'b1;
      exp_oh  = NC'(1);
      exp_bub = 1'b0;
      exp_ovr = 1'b0;
      exp_cnt = '0;
    end else if (armed) begin
      if (cnt_clr) exp_cnt = '0;
      else if (valid_out === 1'b1 && exp_bub && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    logic [NC-2:0] pat;
    int            v0;
    int            k;
    int            j;
    rst       = 1'b1;
    comp_in   = '0;
    sample_en = 1'b0;
    cnt_clr   = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_oh", onehot_out, NC'(1));
    check("rst_valid", NC'(valid_out), '0);
    check("rst_cnt", NC'(bubble_cnt), '0);

    do_sample('0, 0, 1'b0, 1'b0, 1);
    drain("drain_zero");

    do_sample(thermo(100), 100, 1'b0, 1'b0, 1);
    drain("drain_100");

    pat = thermo(100);
    pat[50] = 1'b0;
    do_sample(pat, 100, 1'b1, 1'b0, 1);
    drain("drain_bub50");
    check("cnt_after_bub", NC'(bubble_cnt), NC'(1));

    v0 = n_valid;
    do_sample(thermo(255), 255, 1'b0, 1'b1, 4);
    drain("drain_b2b");
    check("b2b_valids", NC'(n_valid - v0), NC'(4));

    for (int r = 0; r < 24; r++) begin
      case (r % 3)
        0: begin
          k = $urandom_range(0, 255);
          do_sample(thermo(k), k, 1'b0, (k == 255), 1);
        end
        1: begin
          k = $urandom_range(3, 252);
          j = $urandom_range(0, k - 3);
          pat = thermo(k);
          pat[j] = 1'b0;
          do_sample(pat, k, 1'b1, 1'b0, 1 + (r % 2));
        end
        default: begin
          k = $urandom_range(0, 252);
          j = $urandom_range(k + 2, 254);
          pat = thermo(k);
          pat[j] = 1'b1;
          do_sample(pat, k, 1'b1, 1'b0, 1);
        end
      endcase
    end
    drain("drain_rand");

    // Reset with a sample in flight must not produce a result
    v0 = n_valid;
    comp_in = thermo(255);
    repeat (SYNC) tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_flush", NC'(n_valid - v0), '0);
    check("rst_mid_oh", onehot_out, NC'(1));

    pat = thermo(100);
    pat[50] = 1'b0;
    do_sample(pat, 100, 1'b1, 1'b0, 65540);
    drain("drain_sat");
    check("cnt_sat", NC'(bubble_cnt), NC'(16'hFFFF));

    exp_t_push: begin
      exp_t e;
      e.oh  = code_oh(100);
      e.bub = 1'b1;
      e.ovr = 1'b0;
      sample_en = 1'b1;
      sb.push_back(e);
      tick();
      sample_en = 1'b0;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_wins", NC'(bubble_cnt), '0);
    end

    do_sample(pat, 100, 1'b1, 1'b0, 1);
    drain("drain_post_clr");
    tick();
    check("cnt_post_clr", NC'(bubble_cnt), NC'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
